// File: rtl/y86_pkg.sv
// Shared Y86-64 constants, run-state encoding and the pipeline control vector.
package y86_pkg;

    localparam logic [3:0] IHALT   = 4'h0;
    localparam logic [3:0] INOP    = 4'h1;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IOPQ    = 4'h6;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPOPQ   = 4'hB;

    localparam logic [2:0] SAOK = 3'd1;
    localparam logic [2:0] SHLT = 3'd2;
    localparam logic [2:0] SADR = 3'd3;
    localparam logic [2:0] SINS = 3'd4;

    localparam logic [3:0] REG_NONE = 4'hF;

    typedef enum logic [1:0] {
        ST_START,
        ST_RUN,
        ST_HALTED,
        ST_FAULT
    } run_state_e;

    typedef struct packed {
        logic f_stall;
        logic d_stall;
        logic d_bubble;
        logic e_bubble;
        logic m_bubble;
        logic w_stall;
        logic set_cc;
    } ctrl_t;

    // START flushes every stage behind a held PC; HALTED/FAULT freeze everything in place.
    localparam ctrl_t CTRL_START  = '{f_stall: 1'b1, d_stall: 1'b0, d_bubble: 1'b1, e_bubble: 1'b1,
                                      m_bubble: 1'b1, w_stall: 1'b0, set_cc: 1'b0};
    localparam ctrl_t CTRL_FROZEN = '{f_stall: 1'b1, d_stall: 1'b1, d_bubble: 1'b0, e_bubble: 1'b0,
                                      m_bubble: 1'b1, w_stall: 1'b1, set_cc: 1'b0};

endpackage

// File: rtl/pipe_hazard.sv
// Combinational hazard decode: load/use, ret, mispredict and exception detection
// folded into the raw RUN-state control vector.
module pipe_hazard
    import y86_pkg::*;
#(
    parameter logic [3:0] REG_NONE = 4'hF
) (
    input  logic [3:0] D_icode,
    input  logic [3:0] d_srcA,
    input  logic [3:0] d_srcB,
    input  logic [3:0] E_icode,
    input  logic [3:0] E_dstM,
    input  logic       e_Cnd,
    input  logic [3:0] M_icode,
    input  logic [2:0] m_stat,
    input  logic [2:0] W_stat,
    output ctrl_t      raw,
    output logic       lu
);

    logic rt;
    logic mp;
    logic ex_m;
    logic ex_w;

    always_comb begin
        lu   = ((E_icode == IMRMOVQ) || (E_icode == IPOPQ)) && (E_dstM != REG_NONE) &&
               ((E_dstM == d_srcA) || (E_dstM == d_srcB));
        rt   = (D_icode == IRET) || (E_icode == IRET) || (M_icode == IRET);
        mp   = (E_icode == IJXX) && !e_Cnd;
        ex_m = (m_stat != SAOK);
        ex_w = (W_stat != SAOK);

        // A load/use stall wins over the ret bubble so the decode slot is held, not lost.
        raw.f_stall  = lu || rt;
        raw.d_stall  = lu;
        raw.d_bubble = mp || (rt && !lu);
        raw.e_bubble = mp || lu;
        raw.m_bubble = ex_m || ex_w;
        raw.w_stall  = ex_w;
        raw.set_cc   = (E_icode == IOPQ) && !ex_m && !ex_w;
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Y86-64 pipeline control: run-state FSM over the hazard decode, plus performance
// counters built only when PIPE_CTRL_PERF_EN is defined (tied to 0 otherwise).
module pipe_ctrl
    import y86_pkg::*;
#(
    parameter int         CNT_W    = 32,
    parameter logic [3:0] REG_NONE = 4'hF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       D_icode,
    input  logic [3:0]       d_srcA,
    input  logic [3:0]       d_srcB,
    input  logic [3:0]       E_icode,
    input  logic [3:0]       E_dstM,
    input  logic             e_Cnd,
    input  logic [3:0]       M_icode,
    input  logic [2:0]       m_stat,
    input  logic [3:0]       W_icode,
    input  logic [2:0]       W_stat,
    output logic             F_stall,
    output logic             D_stall,
    output logic             D_bubble,
    output logic             E_bubble,
    output logic             M_bubble,
    output logic             W_stall,
    output logic             set_cc,
    output logic             halted,
    output logic             fault,
    output logic [CNT_W-1:0] cyc_cnt,
    output logic [CNT_W-1:0] ret_cnt,
    output logic [CNT_W-1:0] stl_cnt
);

    ctrl_t      raw;
    ctrl_t      ctrl;
    logic       lu;
    run_state_e state_q, state_d;
    logic       halted_q, halted_d;
    logic       fault_q, fault_d;

    pipe_hazard #(
        .REG_NONE (REG_NONE)
    ) u_hazard (
        .D_icode (D_icode),
        .d_srcA  (d_srcA),
        .d_srcB  (d_srcB),
        .E_icode (E_icode),
        .E_dstM  (E_dstM),
        .e_Cnd   (e_Cnd),
        .M_icode (M_icode),
        .m_stat  (m_stat),
        .W_stat  (W_stat),
        .raw     (raw),
        .lu      (lu)
    );

    always_comb begin
        state_d = state_q;
        ctrl    = raw;
        case (state_q)
            ST_START: begin
                state_d = ST_RUN;
                ctrl    = CTRL_START;
            end
            ST_RUN: begin
                if (W_stat == SHLT) begin
                    state_d = ST_HALTED;
                end else if ((W_stat == SADR) || (W_stat == SINS)) begin
                    state_d = ST_FAULT;
                end
            end
            default: ctrl = CTRL_FROZEN;
        endcase
        halted_d = (state_d == ST_HALTED);
        fault_d  = (state_d == ST_FAULT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_START;
            halted_q <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            halted_q <= halted_d;
            fault_q  <= fault_d;
        end
    end

    assign F_stall  = ctrl.f_stall;
    assign D_stall  = ctrl.d_stall;
    assign D_bubble = ctrl.d_bubble;
    assign E_bubble = ctrl.e_bubble;
    assign M_bubble = ctrl.m_bubble;
    assign W_stall  = ctrl.w_stall;
    assign set_cc   = ctrl.set_cc;
    assign halted   = halted_q;
    assign fault    = fault_q;

`ifdef PIPE_CTRL_PERF_EN
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] cyc_cnt_q, cyc_cnt_d;
    logic [CNT_W-1:0] ret_cnt_q, ret_cnt_d;
    logic [CNT_W-1:0] stl_cnt_q, stl_cnt_d;

    // Counters advance only while running, so a halt or fault freezes the final tallies.
    always_comb begin
        cyc_cnt_d = cyc_cnt_q;
        ret_cnt_d = ret_cnt_q;
        stl_cnt_d = stl_cnt_q;
        if (state_q == ST_RUN) begin
            cyc_cnt_d = cyc_cnt_q + CNT_ONE;
            if ((W_stat == SAOK) && (W_icode != INOP)) begin
                ret_cnt_d = ret_cnt_q + CNT_ONE;
            end
            if (lu) begin
                stl_cnt_d = stl_cnt_q + CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc_cnt_q <= '0;
            ret_cnt_q <= '0;
            stl_cnt_q <= '0;
        end else begin
            cyc_cnt_q <= cyc_cnt_d;
            ret_cnt_q <= ret_cnt_d;
            stl_cnt_q <= stl_cnt_d;
        end
    end

    assign cyc_cnt = cyc_cnt_q;
    assign ret_cnt = ret_cnt_q;
    assign stl_cnt = stl_cnt_q;
`else
    logic unused_perf;
    assign unused_perf = ^{W_icode, lu};
    assign cyc_cnt = '0;
    assign ret_cnt = '0;
    assign stl_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: a rule-level model checked every cycle plus
// directed vectors with hand-computed expectations.
module tb_pipe_ctrl;

    localparam int CNT_W = 32;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic [3:0]       D_icode, d_srcA, d_srcB, E_icode, E_dstM, M_icode, W_icode;
    logic             e_Cnd;
    logic [2:0]       m_stat, W_stat;
    logic             F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc;
    logic             halted, fault;
    logic [CNT_W-1:0] cyc_cnt, ret_cnt, stl_cnt;
    logic [6:0]       ctrl_vec;

    int compared   = 0;
    int mismatched = 0;
    logic checkEn  = 1'b0;

    pipe_ctrl #(.CNT_W(CNT_W), .REG_NONE(4'hF)) dut (
        .clk(clk), .rst_n(rst_n),
        .D_icode(D_icode), .d_srcA(d_srcA), .d_srcB(d_srcB),
        .E_icode(E_icode), .E_dstM(E_dstM), .e_Cnd(e_Cnd),
        .M_icode(M_icode), .m_stat(m_stat), .W_icode(W_icode), .W_stat(W_stat),
        .F_stall(F_stall), .D_stall(D_stall), .D_bubble(D_bubble), .E_bubble(E_bubble),
        .M_bubble(M_bubble), .W_stall(W_stall), .set_cc(set_cc),
        .halted(halted), .fault(fault),
        .cyc_cnt(cyc_cnt), .ret_cnt(ret_cnt), .stl_cnt(stl_cnt)
    );

    always #5 clk = ~clk;

    // Order: {F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc}
    assign ctrl_vec = {F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc};

    // Model state: 0 start, 1 run, 2 halted, 3 fault.
    int               m_state;
    logic [CNT_W-1:0] m_cyc, m_ret, m_stl;

    function automatic logic model_lu();
        logic is_load;
        is_load = (E_icode == 4'h5) || (E_icode == 4'hB);
        return is_load && (E_dstM != 4'hF) && ((E_dstM == d_srcA) || (E_dstM == d_srcB));
    endfunction

    function automatic logic [6:0] model_ctrl();
        logic [3:0] stages [3];
        logic       ret_seen, load_use, mispred, exc_m, exc_w;
        if (m_state == 0) return 7'b1011100;
        if (m_state >= 2) return 7'b1100110;
        stages[0] = D_icode;
        stages[1] = E_icode;
        stages[2] = M_icode;
        ret_seen = 1'b0;
        foreach (stages[i]) if (stages[i] == 4'h9) ret_seen = 1'b1;
        load_use = model_lu();
        mispred  = (E_icode == 4'h7) && (e_Cnd == 1'b0);
        exc_m    = (m_stat != 3'd1);
        exc_w    = (W_stat != 3'd1);
        if (load_use)
            return {1'b1, 1'b1, 1'b0, 1'b1, exc_m || exc_w, exc_w, 1'b0};
        return {ret_seen, 1'b0, mispred || ret_seen, mispred, exc_m || exc_w, exc_w,
                (E_icode == 4'h6) && !exc_m && !exc_w};
    endfunction

    function automatic logic [CNT_W-1:0] exp_cnt(input logic [CNT_W-1:0] v);
`ifdef PIPE_CTRL_PERF_EN
        return v;
`else
        return (v & '0);
`endif
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_state <= 0;
            m_cyc   <= '0;
            m_ret   <= '0;
            m_stl   <= '0;
        end else if (m_state == 0) begin
            m_state <= 1;
        end else if (m_state == 1) begin
            m_cyc <= m_cyc + 1;
            if (W_stat == 3'd1 && W_icode != 4'h1) m_ret <= m_ret + 1;
            if (model_lu()) m_stl <= m_stl + 1;
            if (W_stat == 3'd2) m_state <= 2;
            else if (W_stat == 3'd3 || W_stat == 3'd4) m_state <= 3;
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (checkEn) begin
            checkOutput("model_ctrl", ctrl_vec, model_ctrl());
            checkOutput("model_halted", halted, m_state == 2);
            checkOutput("model_fault", fault, m_state == 3);
            checkOutput("model_cyc", cyc_cnt, exp_cnt(m_cyc));
            checkOutput("model_ret", ret_cnt, exp_cnt(m_ret));
            checkOutput("model_stl", stl_cnt, exp_cnt(m_stl));
        end
    end

    task automatic applyStimulus(input logic [3:0] di, input logic [3:0] sa, input logic [3:0] sb,
                                 input logic [3:0] ei, input logic [3:0] edm, input logic ec,
                                 input logic [3:0] mi, input logic [2:0] ms,
                                 input logic [3:0] wi, input logic [2:0] ws);
        D_icode = di; d_srcA = sa; d_srcB = sb;
        E_icode = ei; E_dstM = edm; e_Cnd = ec;
        M_icode = mi; m_stat = ms; W_icode = wi; W_stat = ws;
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        applyStimulus(4'h1, 4'hF, 4'hF, 4'h1, 4'hF, 1'b1, 4'h1, 3'd1, 4'h1, 3'd1);
        rst_n = 1'b0;
        #1 checkEn = 1'b1;
        checkOutput("rst_F_stall", F_stall, 1);
        checkOutput("rst_E_bubble", E_bubble, 1);
        checkOutput("rst_cyc_cnt", cyc_cnt, 0);
        checkOutput("rst_halted", halted, 0);
        #4 rst_n = 1'b1;
        step();
        checkOutput("idle_ctrl", ctrl_vec, 7'b0000000);

        // Load/use held three cycles
        applyStimulus(4'h1, 4'h3, 4'hF, 4'h5, 4'h3, 1'b1, 4'h1, 3'd1, 4'h1, 3'd1);
        for (int i = 0; i < 3; i++) begin
            checkOutput("lu_ctrl", ctrl_vec, 7'b1101000);
            step();
        end
        checkOutput("lu_stl_cnt", stl_cnt, exp_cnt(3));

        // ret moving through D, E, M
        for (int i = 0; i < 3; i++) begin
            applyStimulus(4'h9, 4'hF, 4'hF, 4'h1, 4'hF, 1'b1, 4'h1, 3'd1, 4'h1, 3'd1);
            checkOutput("ret_d_ctrl", ctrl_vec, 7'b1010000);
            step();
        end
        applyStimulus(4'h1, 4'hF, 4'hF, 4'h9, 4'hF, 1'b1, 4'h1, 3'd1, 4'h1, 3'd1);
        checkOutput("ret_e_ctrl", ctrl_vec, 7'b1010000);
        step();
        applyStimulus(4'h1, 4'hF, 4'hF, 4'h1, 4'hF, 1'b1, 4'h9, 3'd1, 4'h1, 3'd1);
        checkOutput("ret_m_ctrl", ctrl_vec, 7'b1010000);
        step();
        applyStimulus(4'h9, 4'hF, 4'h3, 4'hB, 4'h3, 1'b1, 4'h1, 3'd1, 4'h1, 3'd1);
        checkOutput("ret_lu_D_bubble", D_bubble, 0);
        checkOutput("ret_lu_D_stall", D_stall, 1);
        step();
        checkOutput("ret_lu_stl_cnt", stl_cnt, exp_cnt(4));

        // Mispredict, then correctly predicted jump
        applyStimulus(4'h1, 4'hF, 4'hF, 4'h7, 4'hF, 1'b0, 4'h1, 3'd1, 4'h1, 3'd1);
        checkOutput("mp_ctrl", ctrl_vec, 7'b0011000);
        step();
        applyStimulus(4'h1, 4'hF, 4'hF, 4'h7, 4'hF, 1'b1, 4'h1, 3'd1, 4'h1, 3'd1);
        checkOutput("jmp_taken_ctrl", ctrl_vec, 7'b0000000);
        step();

        // OPq sets CC, then memory exception, then writeback exception into FAULT
        applyStimulus(4'h1, 4'hF, 4'hF, 4'h6, 4'hF, 1'b1, 4'h1, 3'd1, 4'h1, 3'd1);
        checkOutput("opq_set_cc", ctrl_vec, 7'b0000001);
        step();
        applyStimulus(4'h1, 4'hF, 4'hF, 4'h6, 4'hF, 1'b1, 4'h5, 3'd3, 4'h1, 3'd1);
        checkOutput("exm_ctrl", ctrl_vec, 7'b0000100);
        step();
        applyStimulus(4'h1, 4'hF, 4'hF, 4'h6, 4'hF, 1'b1, 4'h1, 3'd1, 4'h5, 3'd3);
        checkOutput("exw_ctrl", ctrl_vec, 7'b0000110);
        checkOutput("exw_fault_pre", fault, 0);
        step();
        checkOutput("fault_set", fault, 1);
        applyStimulus(4'h9, 4'h3, 4'hF, 4'h5, 4'h3, 1'b0, 4'h6, 3'd1, 4'h6, 3'd1);
        for (int i = 0; i < 3; i++) begin
            checkOutput("fault_frozen_ctrl", ctrl_vec, 7'b1100110);
            step();
        end

        // Asynchronous reset in the middle of FAULT
        #2 rst_n = 1'b0;
        #1;
        checkOutput("midrst_fault", fault, 0);
        checkOutput("midrst_ctrl", ctrl_vec, 7'b1011100);
        checkOutput("midrst_stl_cnt", stl_cnt, 0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        step();

        // Five retirements, a NOP, then halt
        applyStimulus(4'h1, 4'hF, 4'hF, 4'h1, 4'hF, 1'b1, 4'h1, 3'd1, 4'h6, 3'd1);
        repeat (5) step();
        applyStimulus(4'h1, 4'hF, 4'hF, 4'h1, 4'hF, 1'b1, 4'h1, 3'd1, 4'h1, 3'd1);
        step();
        applyStimulus(4'h1, 4'hF, 4'hF, 4'h1, 4'hF, 1'b1, 4'h1, 3'd1, 4'h0, 3'd2);
        checkOutput("hlt_ctrl", ctrl_vec, 7'b0000110);
        checkOutput("hlt_halted_pre", halted, 0);
        step();
        checkOutput("hlt_halted", halted, 1);
        checkOutput("hlt_ret_cnt", ret_cnt, exp_cnt(5));
        applyStimulus(4'h1, 4'hF, 4'hF, 4'h1, 4'hF, 1'b1, 4'h1, 3'd1, 4'h6, 3'd1);
        repeat (2) step();
        checkOutput("hlt_ret_frozen", ret_cnt, exp_cnt(5));
        checkOutput("hlt_ctrl_frozen", ctrl_vec, 7'b1100110);

        @(negedge clk);
        #1 checkEn = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Pipeline control unit for the five-stage Y86-64 pipeline (fetch, decode, execute, memory, writeback).
- Watches stage icodes, register IDs, the branch outcome and stage status.
- Issues the stall and bubble controls for every pipeline register, plus the condition-code write enable.
- Holds a run-state machine that freezes the machine on halt or fault, and optional performance counters.

Parameters:
- CNT_W, 32, width of each performance counter.
- REG_NONE, 4'hF, register ID meaning "no register".

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- D_icode  in  4  icode held in the decode pipeline register.
- d_srcA  in  4  decode source register A.
- d_srcB  in  4  decode source register B.
- E_icode  in  4  icode held in the execute register.
- E_dstM  in  4  memory-load destination register in the execute register.
- e_Cnd  in  1  branch/cmov condition computed by execute.
- M_icode  in  4  icode held in the memory register.
- m_stat  in  3  status produced by the memory stage.
- W_icode  in  4  icode held in the writeback register.
- W_stat  in  3  status held in the writeback register.
- F_stall  out  1  hold the PC register.
- D_stall  out  1  hold the decode register.
- D_bubble  out  1  load a NOP into the decode register.
- E_bubble  out  1  load a NOP into the execute register.
- M_bubble  out  1  load a NOP into the memory register.
- W_stall  out  1  hold the writeback register.
- set_cc  out  1  condition-code write enable.
- halted  out  1  state is HALTED.
- fault  out  1  state is FAULT.
- cyc_cnt  out  CNT_W  cycles spent in RUN.
- ret_cnt  out  CNT_W  retired instructions.
- stl_cnt  out  CNT_W  load/use stall cycles.

Behaviour:
- Constants:
  - icodes: IHALT 0, INOP 1, IOPQ 6, IJXX 7, IRET 9, IMRMOVQ 5, IPOPQ B.
  - status: SAOK 1, SHLT 2, SADR 3, SINS 4.
- States: START, RUN, HALTED, FAULT.
  - Reset enters START asynchronously; this applies mid-operation as well. All counters clear to 0.
  - START to RUN on the first clock edge after rst_n goes high.
  - RUN to HALTED when W_stat == SHLT.
  - RUN to FAULT when W_stat is SADR or SINS.
  - HALTED and FAULT are terminal until reset.
- halted and fault are registered decodes of the state; both are 0 after reset.
- All stall, bubble and set_cc outputs are combinational from the inputs and the current state, with zero latency, so they act on the same edge the pipeline registers capture.
- In START:
  - F_stall=1, D_bubble=1, E_bubble=1, M_bubble=1.
  - D_stall=0, W_stall=0, set_cc=0.
- In HALTED and FAULT:
  - F_stall=1, D_stall=1, W_stall=1, M_bubble=1, set_cc=0.
  - D_bubble=0, E_bubble=0.
- In RUN:
  - lu = (E_icode is IMRMOVQ or IPOPQ) && E_dstM != REG_NONE && (E_dstM == d_srcA || E_dstM == d_srcB).
  - rt = IRET present in D_icode, E_icode or M_icode.
  - mp = E_icode == IJXX && !e_Cnd.
  - ex_m = m_stat != SAOK.
  - ex_w = W_stat != SAOK.
  - F_stall = lu || rt.
  - D_stall = lu.
  - D_bubble = mp || (rt && !lu).
  - E_bubble = mp || lu.
  - M_bubble = ex_m || ex_w.
  - W_stall = ex_w.
  - set_cc = E_icode == IOPQ && !ex_m && !ex_w.
- Simultaneous conditions:
  - lu and rt together: stall D and do not bubble it.
  - mp with lu cannot occur (jXX has no dstM), and mp takes the bubble path.
- Counters, counting only in RUN:
  - cyc_cnt increments every RUN cycle.
  - ret_cnt increments when W_stat == SAOK && W_icode != INOP. Bubbles and real NOPs are both excluded.
  - stl_cnt increments when lu is 1.
  - Counters wrap modulo 2^CNT_W and freeze in HALTED and FAULT.

Optional Feature:
- Macro: PIPE_CTRL_PERF_EN.
- Defined: the three counters are implemented as specified.
- Undefined: cyc_cnt, ret_cnt and stl_cnt are tied to 0 and no counter flops are built. Control outputs are unchanged.

Decomposition:
- Shared package (y86_pkg) holds:
  - icode constants I*;
  - stat constants S*;
  - REG_NONE;
  - the state encoding for START, RUN, HALTED, FAULT.
- One natural sub-module, pipe_hazard: purely combinational lu/rt/mp/ex decode producing the raw control vector.
- pipe_ctrl wraps pipe_hazard with the FSM override muxing and the counters.

Test Plan:
- Reset, then release rst_n: while low, F_stall=1 and E_bubble=1 with counters 0. After the first edge, state is RUN, and idle inputs (all stat SAOK, icodes INOP) give all controls 0.
- Load/use: E_icode=5, E_dstM=3, d_srcA=3 -> F_stall=1, D_stall=1, E_bubble=1, D_bubble=0. stl_cnt increments by 1 per cycle held.
- ret: D_icode=9 for 3 cycles, then E_icode=9, then M_icode=9 -> F_stall=1 and D_bubble=1 in each of those cycles. With lu also true, D_bubble=0 and D_stall=1.
- Mispredict: E_icode=7, e_Cnd=0 -> D_bubble=1, E_bubble=1, F_stall=0. With e_Cnd=1, all controls are 0.
- Exception: m_stat=3 -> M_bubble=1 and set_cc=0 with E_icode=6. Next cycle W_stat=3 -> W_stall=1, then fault=1 after the edge; outputs stay frozen and counters stop. Assert rst_n=0 mid-FAULT -> START, counters 0.
- Halt and retire count: retire 5 non-NOP SAOK instructions, then W_stat=2 -> ret_cnt=5 and halted=1 after the edge. With PIPE_CTRL_PERF_EN undefined, all counters read 0.
